// File: rtl/sp_ram_arb.sv
// Two-master arbiter in front of a single-port RAM with one-cycle read latency.
// Optional macro SP_RAM_ARB_RR_EN selects round-robin arbitration (default: master 1 wins contention).
module sp_ram_arb #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rstn_i,
    input  logic [1:0]                     req_i,
    input  logic [1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [1:0]                     we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]   be_i,
    input  logic [1:0][DATA_WIDTH-1:0]     wdata_i,
    output logic [1:0]                     gnt_o,
    output logic [1:0]                     rvalid_o,
    output logic [1:0][DATA_WIDTH-1:0]     rdata_o,
    output logic                           ram_en_o,
    output logic                           ram_we_o,
    output logic [ADDR_WIDTH-1:0]          ram_addr_o,
    output logic [DATA_WIDTH-1:0]          ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        ram_be_o,
    input  logic [DATA_WIDTH-1:0]          ram_rdata_i
);

    logic       w_sel;
    logic [1:0] w_gnt;
    logic       r_vld;
    logic       r_owner;
    logic       r_we;

`ifdef SP_RAM_ARB_RR_EN
    logic r_ptr;

    // Pointer names the preferred master; it moves away after that master is served.
    assign w_sel = (req_i == 2'b11) ? r_ptr : req_i[1];

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ptr <= 1'b0;
        end else if (|w_gnt && (w_sel == r_ptr)) begin
            r_ptr <= ~r_ptr;
        end
    end
`else
    assign w_sel = req_i[1];
`endif

    // Grants are suppressed while reset is held so the RAM sees no stray access.
    assign w_gnt       = (rstn_i && |req_i) ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    assign gnt_o       = w_gnt;
    assign ram_en_o    = |w_gnt;
    assign ram_we_o    = ram_en_o & we_i[w_sel];
    assign ram_addr_o  = addr_i[w_sel];
    assign ram_wdata_o = wdata_i[w_sel];
    assign ram_be_o    = be_i[w_sel];

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_vld   <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_vld <= |w_gnt;
            if (|w_gnt) begin
                r_owner <= w_sel;
                r_we    <= we_i[w_sel];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic                  w_rsp;
            logic                  w_rd_rsp;
            logic [DATA_WIDTH-1:0] r_hold;

            assign w_rsp       = r_vld && (r_owner == 1'(gi));
            assign w_rd_rsp    = w_rsp && !r_we;
            assign rvalid_o[gi] = w_rsp;
            // Live RAM data is forwarded on the response cycle; the copy holds it afterwards.
            assign rdata_o[gi]  = w_rd_rsp ? ram_rdata_i : r_hold;

            always_ff @(posedge clk or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_hold <= '0;
                end else if (w_rd_rsp) begin
                    r_hold <= ram_rdata_i;
                end
            end
        end
    endgenerate

endmodule

// File: doc/sp_ram_arb.md
SP_RAM_ARB -- requirements
Module: sp_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, meaning byte-address width presented to the RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data word width (multiple of 8).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  [1:0]  per-master request (master 0 = instr, 1 = data).
REQ-006 SHALL have port addr_i  input  [1:0][ADDR_WIDTH-1:0]  per-master byte address.
REQ-007 SHALL have port we_i  input  [1:0]  per-master write enable.
REQ-008 SHALL have port be_i  input  [1:0][DATA_WIDTH/8-1:0]  per-master byte enables.
REQ-009 SHALL have port wdata_i  input  [1:0][DATA_WIDTH-1:0]  per-master write data.
REQ-010 SHALL have port gnt_o  output  [1:0]  per-master grant, same cycle as accepted request.
REQ-011 SHALL have port rvalid_o  output  [1:0]  per-master response valid.
REQ-012 SHALL have port rdata_o  output  [1:0][DATA_WIDTH-1:0]  per-master read data.
REQ-013 SHALL have ports ram_en_o, ram_we_o (1), ram_addr_o (ADDR_WIDTH), ram_wdata_o (DATA_WIDTH), ram_be_o (DATA_WIDTH/8), all outputs, driving the RAM wrapper.
REQ-014 SHALL have port ram_rdata_i  input  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o.

Function
REQ-015 SHALL grant at most one master per cycle; gnt_o combinational from req_i and priority state.
REQ-016 SHALL, with one requester, grant it in the same cycle.
REQ-017 SHALL, with both requesting, grant per the priority rule of REQ-030/031.
REQ-018 SHALL drive ram_en_o = |gnt_o and route the granted master's addr/we/be/wdata to ram_*_o; with no grant, ram_en_o = 0 and ram_we_o = 0.
REQ-019 SHALL register owner index and we of each granted request; rvalid_o[owner] = 1 exactly one cycle after grant, for reads and writes.
REQ-020 SHALL set rdata_o[p] = ram_rdata_i while rvalid_o[p] is high for a read response.
REQ-021 SHALL hold per-master read register hold[p], loaded from ram_rdata_i on each read response to p; rdata_o[p] = hold[p] otherwise, including write responses.
REQ-022 SHALL allow back-to-back grants every cycle; throughput 1 access/cycle, latency 1 cycle.
REQ-023 SHALL never assert both rvalid_o bits in the same cycle.
REQ-024 SHALL leave hold[p] unchanged on write responses; write data does not bypass to rdata_o.

Reset
REQ-025 SHALL, on rstn_i low, asynchronously clear rvalid_o, owner/we registers, priority pointer (to master 0) and hold[] (to 0).
REQ-026 SHALL, on reset assertion with a response pending, drop that response: no rvalid_o after release.
REQ-027 SHALL keep gnt_o and ram_en_o at 0 while rstn_i is low regardless of req_i.
REQ-028 SHALL accept requests from the first rising edge after rstn_i deasserts.
REQ-029 SHALL guarantee that after reset rdata_o = 0 on both masters until the first read response.

Configuration
REQ-030 SHALL, with macro SP_RAM_ARB_RR_EN defined, use round-robin: 1-bit pointer names the preferred master on contention and toggles to the other master after every grant to the preferred one.
REQ-031 SHALL, without SP_RAM_ARB_RR_EN, use fixed priority: master 1 (data) always wins contention; pointer logic absent.

Verification
REQ-032 SHALL cover: master 0 read addr 0x0040, RAM returns 0xDEADBEEF -> gnt_o=01 cycle 0, rvalid_o=01 and rdata_o[0]=0xDEADBEEF cycle 1, hold thereafter.
REQ-033 SHALL cover: master 1 write 0x1234_5678 be=0011 addr 0x0100 -> ram_we_o=1, ram_be_o=0011 same cycle; rvalid_o=10 next cycle; rdata_o[1] unchanged.
REQ-034 SHALL cover: both masters request continuously 4 cycles with SP_RAM_ARB_RR_EN -> grants 01,10,01,10; without -> 10,10,10,10.
REQ-035 SHALL cover: reset asserted the cycle after a grant -> rvalid_o stays 0, rdata_o both 0 after release.
REQ-036 SHALL cover: alternating single requests master 0 / master 1 every cycle for 8 cycles -> one rvalid per cycle, correct owner, no idle cycle.
